mac_seq_ctrl: RTL and testbench

Sequencer for the weight-stationary INT8 MAC lane array in the MNIST CNN accelerator. It accepts a dot-product command (length, activation base, weight base) and issues read addresses to the activation and weight buffers. It drives the shared `mac_en`/`mac_clr` controls of `N_MAC` mac lanes in lockstep with 1-cycle buffer read latency, then presents the finished accumulators on a valid/ready result port.

---
 rtl/mac_seq_pkg.sv | 15 +
 rtl/mac_seq_if.sv | 35 +++
 rtl/mac_seq_agen.sv | 46 ++++
 rtl/mac_seq_ctrl.sv | 110 +++++++++++
 tb/tb_mac_seq_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the MAC lane sequencer.
package mac_seq_pkg;

   localparam int ACC_W  = 32;  // lane accumulator width
   localparam int DATA_W = 8;   // activation / weight element width

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_LOAD,
      ST_DRAIN,
      ST_HOLD
   } mac_seq_state_e;

endpackage

// File: rtl/mac_seq_if.sv
// Command, buffer-read, lane-control and result signals of the MAC sequencer.
// slave: the sequencer itself; master: the surrounding datapath / command source.
interface mac_seq_if #(
   parameter int N_MAC  = 8,
   parameter int ADDR_W = 10,
   parameter int K_W    = 10
);
   logic                  start;
   logic [K_W-1:0]        k_len;
   logic [ADDR_W-1:0]     act_base;
   logic [ADDR_W-1:0]     wgt_base;
   logic                  busy;
   logic                  act_rd_en;
   logic                  wgt_rd_en;
   logic [ADDR_W-1:0]     act_rd_addr;
   logic [ADDR_W-1:0]     wgt_rd_addr;
   logic                  mac_clr;
   logic                  mac_en;
   logic [N_MAC*32-1:0]   mac_acc;
   logic                  res_valid;
   logic                  res_ready;
   logic [N_MAC*32-1:0]   res_data;

   modport slave (
      input  start, k_len, act_base, wgt_base, mac_acc, res_ready,
      output busy, act_rd_en, wgt_rd_en, act_rd_addr, wgt_rd_addr,
             mac_clr, mac_en, res_valid, res_data
   );

   modport master (
      output start, k_len, act_base, wgt_base, mac_acc, res_ready,
      input  busy, act_rd_en, wgt_rd_en, act_rd_addr, wgt_rd_addr,
             mac_clr, mac_en, res_valid, res_data
   );
endinterface

// File: rtl/mac_seq_agen.sv
// Address generator shared by the activation and weight buffers: latches the
// command, steps a common element index and flags the last index.
module mac_seq_agen #(
   parameter int ADDR_W = 10,
   parameter int K_W    = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              adv,
   input  logic [K_W-1:0]    k_len,
   input  logic [ADDR_W-1:0] act_base,
   input  logic [ADDR_W-1:0] wgt_base,
   output logic [ADDR_W-1:0] act_addr,
   output logic [ADDR_W-1:0] wgt_addr,
   output logic              last,
   output logic              k_zero
);
   logic [K_W-1:0]    k_reg;
   logic [K_W-1:0]    idx_reg;
   logic [ADDR_W-1:0] act_base_reg;
   logic [ADDR_W-1:0] wgt_base_reg;

   // Latch the command on acceptance, then advance the index once per issued read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_reg        <= '0;
         idx_reg      <= '0;
         act_base_reg <= '0;
         wgt_base_reg <= '0;
      end else if (load) begin
         k_reg        <= k_len;
         idx_reg      <= '0;
         act_base_reg <= act_base;
         wgt_base_reg <= wgt_base;
      end else if (adv) begin
         idx_reg      <= idx_reg + K_W'(1);
      end
   end

   // Addresses wrap silently modulo 2^ADDR_W.
   assign act_addr = act_base_reg + ADDR_W'(idx_reg);
   assign wgt_addr = wgt_base_reg + ADDR_W'(idx_reg);
   assign last     = (idx_reg == k_reg - K_W'(1));
   assign k_zero   = (k_reg == '0);
endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for the weight-stationary INT8 MAC lane array.
// Optional build macro: MAC_SEQ_RELU_EN fuses a ReLU into the result port.
module mac_seq_ctrl
   import mac_seq_pkg::*;
#(
   parameter int N_MAC  = 8,
   parameter int ADDR_W = 10,
   parameter int K_W    = 10
) (
   input  logic     clk,
   input  logic     rst,
   mac_seq_if.slave bus
);
   mac_seq_state_e    state_reg, state_next;
   logic              rd_en_dly_reg;
   logic              rd_en;
   logic              load;
   logic              mac_clr_c;
   logic              res_valid_c;
   logic [ADDR_W-1:0] act_addr, wgt_addr;
   logic              last, k_zero;

   mac_seq_agen #(.ADDR_W(ADDR_W), .K_W(K_W)) u_agen (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .adv      (rd_en),
      .k_len    (bus.k_len),
      .act_base (bus.act_base),
      .wgt_base (bus.wgt_base),
      .act_addr (act_addr),
      .wgt_addr (wgt_addr),
      .last     (last),
      .k_zero   (k_zero)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   // Read enable delayed one cycle so mac_en lines up with the buffer read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_en_dly_reg <= 1'b0;
      else     rd_en_dly_reg <= rd_en;
   end

   // Next-state and per-state controls.
   always_comb begin
      state_next  = state_reg;
      rd_en       = 1'b0;
      load        = 1'b0;
      mac_clr_c   = 1'b0;
      res_valid_c = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (bus.start) begin
               load       = 1'b1;
               state_next = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            mac_clr_c = 1'b1;
            if (k_zero) begin
               state_next = ST_HOLD;
            end else begin
               rd_en      = 1'b1;
               state_next = last ? ST_DRAIN : ST_LOAD;
            end
         end
         ST_LOAD: begin
            rd_en = 1'b1;
            if (last) state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            state_next = ST_HOLD;
         end
         ST_HOLD: begin
            res_valid_c = 1'b1;
            if (bus.res_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign bus.busy        = (state_reg != ST_IDLE);
   assign bus.act_rd_en   = rd_en;
   assign bus.wgt_rd_en   = rd_en;
   assign bus.act_rd_addr = rd_en ? act_addr : '0;
   assign bus.wgt_rd_addr = rd_en ? wgt_addr : '0;
   assign bus.mac_clr     = mac_clr_c;
   assign bus.mac_en      = rd_en_dly_reg;
   assign bus.res_valid   = res_valid_c;

   // Result lanes follow mac_acc combinationally while valid and read as zero
   // otherwise, so the port is 0 during and after reset.
   generate
      for (genvar gi = 0; gi < N_MAC; gi++) begin : g_lane
         logic [ACC_W-1:0] lane;
         assign lane = bus.mac_acc[gi*ACC_W +: ACC_W];
`ifdef MAC_SEQ_RELU_EN
         assign bus.res_data[gi*ACC_W +: ACC_W] =
            (res_valid_c && !lane[ACC_W-1]) ? lane : '0;
`else
         assign bus.res_data[gi*ACC_W +: ACC_W] = res_valid_c ? lane : '0;
`endif
      end
   endgenerate
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: behavioural buffers and MAC lanes drive
// the DUT; expected timing and sums come from the dot-product definition.
module tb_mac_seq_ctrl;
   import mac_seq_pkg::*;

   localparam int N_MAC  = 8;
   localparam int ADDR_W = 10;
   localparam int K_W    = 10;
   localparam int RES_W  = N_MAC * ACC_W;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef logic [RES_W-1:0] val_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mac_seq_if #(.N_MAC(N_MAC), .ADDR_W(ADDR_W), .K_W(K_W)) bus ();

   mac_seq_ctrl #(.N_MAC(N_MAC), .ADDR_W(ADDR_W), .K_W(K_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Buffers with 1-cycle read latency and MAC lanes.
   byte act_mem [DEPTH];
   byte wgt_mem [N_MAC][DEPTH];
   byte act_q;
   byte wgt_q   [N_MAC];
   int  lane_acc[N_MAC];

   always @(posedge clk) begin
      if (bus.act_rd_en) act_q <= act_mem[bus.act_rd_addr];
      for (int i = 0; i < N_MAC; i++) begin
         if (bus.wgt_rd_en) wgt_q[i] <= wgt_mem[i][bus.wgt_rd_addr];
         if (bus.mac_clr)     lane_acc[i] <= 0;
         else if (bus.mac_en) lane_acc[i] <= lane_acc[i] + int'(act_q) * int'(wgt_q[i]);
      end
   end

   always_comb begin
      bus.mac_acc = '0;
      for (int i = 0; i < N_MAC; i++) bus.mac_acc[i*ACC_W +: ACC_W] = lane_acc[i];
   end

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input val_t got, input val_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected result: plain dot product per lane over wrapped addresses.
   function automatic val_t ref_result(input int k, input int ab, input int wb);
      val_t r = '0;
      for (int l = 0; l < N_MAC; l++) begin
         int s = 0;
         for (int j = 0; j < k; j++)
            s += int'(act_mem[(ab + j) % DEPTH]) * int'(wgt_mem[l][(wb + j) % DEPTH]);
`ifdef MAC_SEQ_RELU_EN
         if (s < 0) s = 0;
`endif
         r[l*ACC_W +: ACC_W] = s;
      end
      return r;
   endfunction

   task automatic check_all_zero(input string tag);
      check_val({tag, "_busy"}, val_t'(bus.busy), '0);
      check_val({tag, "_act_en"}, val_t'(bus.act_rd_en), '0);
      check_val({tag, "_wgt_en"}, val_t'(bus.wgt_rd_en), '0);
      check_val({tag, "_act_addr"}, val_t'(bus.act_rd_addr), '0);
      check_val({tag, "_wgt_addr"}, val_t'(bus.wgt_rd_addr), '0);
      check_val({tag, "_clr"}, val_t'(bus.mac_clr), '0);
      check_val({tag, "_mac_en"}, val_t'(bus.mac_en), '0);
      check_val({tag, "_valid"}, val_t'(bus.res_valid), '0);
      check_val({tag, "_data"}, bus.res_data, '0);
   endtask

   // One command: called just after a falling edge in IDLE, returns after the
   // falling edge of the IDLE bubble following the handshake.
   task automatic run_cmd(input int k, input int ab, input int wb, input int delay,
                          input bit poke_start, output val_t got_res);
      val_t exp_res;
      int   hs;
      exp_res = ref_result(k, ab, wb);
      hs      = k + 2 + delay;
      got_res = '0;
      bus.start    = 1'b1;
      bus.k_len    = K_W'(k);
      bus.act_base = ADDR_W'(ab);
      bus.wgt_base = ADDR_W'(wb);
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int c = 1; c <= hs; c++) begin
         @(negedge clk);
         check_val("busy", val_t'(bus.busy), val_t'(1));
         check_val("mac_clr", val_t'(bus.mac_clr), val_t'(c == 1));
         check_val("act_rd_en", val_t'(bus.act_rd_en), val_t'(c <= k));
         check_val("wgt_rd_en", val_t'(bus.wgt_rd_en), val_t'(c <= k));
         if (c <= k) begin
            check_val("act_rd_addr", val_t'(bus.act_rd_addr), val_t'((ab + c - 1) % DEPTH));
            check_val("wgt_rd_addr", val_t'(bus.wgt_rd_addr), val_t'((wb + c - 1) % DEPTH));
         end
         check_val("mac_en", val_t'(bus.mac_en), val_t'(c >= 2 && c <= k + 1));
         check_val("res_valid", val_t'(bus.res_valid), val_t'(c >= k + 2));
         if (c >= k + 2) begin
            check_val("res_data", bus.res_data, exp_res);
            if (c == k + 2) got_res = bus.res_data;
         end
         bus.res_ready = (c == hs);
         if (poke_start) bus.start = (c >= k + 2);
      end
      @(posedge clk);
      #1;
      bus.res_ready = 1'b0;
      bus.start     = 1'b0;
      @(negedge clk);
      check_val("idle_busy", val_t'(bus.busy), '0);
      check_val("idle_valid", val_t'(bus.res_valid), '0);
      check_val("idle_clr", val_t'(bus.mac_clr), '0);
      $display("cmd k=%0d act_base=%0h wgt_base=%0h hold=%0d lane0=%0h", k, ab, wb, delay,
               got_res[ACC_W-1:0]);
   endtask

   val_t res;

   initial begin
      bus.start     = 1'b0;
      bus.k_len     = '0;
      bus.act_base  = '0;
      bus.wgt_base  = '0;
      bus.res_ready = 1'b0;
      for (int a = 0; a < DEPTH; a++) begin
         act_mem[a] = byte'($urandom);
         for (int l = 0; l < N_MAC; l++) wgt_mem[l][a] = byte'($urandom);
      end

      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // K=4 dot product with a known lane-0 sum of 70.
      for (int j = 0; j < 4; j++) begin
         act_mem[j]         = byte'(j + 1);
         wgt_mem[0][16 + j] = byte'(j + 5);
      end
      run_cmd(4, 0, 16, 0, 1'b0, res);
      check_val("k4_lane0", val_t'(res[ACC_W-1:0]), val_t'(70));

      // K=0: clear only, every lane reads zero.
      run_cmd(0, 5, 7, 0, 1'b0, res);
      check_val("k0_zero", res, '0);

      // Address wrap-around.
      run_cmd(4, 'h3FE, 'h3FD, 0, 1'b0, res);

      // Back-pressure with start pulsed during HOLD, then an immediate command.
      run_cmd(3, 100, 200, 5, 1'b1, res);
      run_cmd(2, 300, 400, 0, 1'b0, res);

      // Reset at cycle 3 of a K=8 command.
      bus.start    = 1'b1;
      bus.k_len    = K_W'(8);
      bus.act_base = ADDR_W'(50);
      bus.wgt_base = ADDR_W'(60);
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int c = 1; c <= 3; c++) @(negedge clk);
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      $display("reset asserted mid-command");
      @(negedge clk);
      rst = 1'b0;
      run_cmd(2, 70, 80, 1, 1'b0, res);

      // Negative lane sum: -3 * 4 = -12.
      act_mem['h200]    = -8'sd3;
      wgt_mem[0]['h300] = 8'sd4;
      run_cmd(1, 'h200, 'h300, 0, 1'b0, res);
`ifdef MAC_SEQ_RELU_EN
      check_val("relu_lane0", val_t'(res[ACC_W-1:0]), '0);
`else
      check_val("relu_lane0", val_t'(res[ACC_W-1:0]), val_t'(32'hFFFF_FFF4));
`endif

      // Randomized commands.
      for (int n = 0; n < 25; n++) begin
         run_cmd(int'($urandom_range(0, 24)), int'($urandom_range(0, DEPTH - 1)),
                 int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 4)),
                 1'($urandom_range(0, 1)), res);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
